// File: rtl/rtr_xbr_allocator_pkg.sv
// Shared router constants: port-count limits, packet-lock enables and the
// round-robin pointer helper used by every output arbiter.
package rtr_xbr_allocator_pkg;

    localparam int unsigned num_ports_min = 2;
    localparam int unsigned num_ports_max = 16;

    localparam bit lock_packets_off = 1'b0;
    localparam bit lock_packets_on  = 1'b1;

    // Wide enough to index any port up to num_ports_max.
    localparam int unsigned ptr_w = 4;

    function automatic logic [ptr_w-1:0] rr_next(input logic [ptr_w-1:0] idx,
                                                 input int unsigned       n);
        return (idx == ptr_w'(n - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rtr_xbr_allocator_out_arbiter.sv
// Per-output round-robin arbiter with optional head-to-tail packet lock;
// the grant vector is registered and drives one crossbar output block.
module rtr_xbr_out_arbiter
    import rtr_xbr_allocator_pkg::*;
#(
    parameter int unsigned num_ports    = 5,
    parameter bit          lock_packets = lock_packets_on
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [num_ports-1:0] req,
    input  logic [num_ports-1:0] tail,
    input  logic                 ready,
    output logic [num_ports-1:0] gnt,
    output logic                 busy
);

    logic [ptr_w-1:0]     ptr_q, ptr_d;
    logic                 lock_q, lock_d;
    logic [ptr_w-1:0]     lock_ip_q, lock_ip_d;
    logic [num_ports-1:0] gnt_q, gnt_d;
    logic [num_ports-1:0] eligible;
    logic                 found_hi, found_lo, grant, sel_tail;
    logic [ptr_w-1:0]     sel_hi, sel_lo, sel;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        eligible = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = 0; i < num_ports; i++) begin
            eligible[i] = req[i] && (!lock_q || lock_ip_q == ptr_w'(i));
            // Lowest eligible index at or above the pointer wins; otherwise wrap.
            if (eligible[i] && !found_lo) begin
                found_lo = 1'b1;
                sel_lo   = ptr_w'(i);
            end
            if (eligible[i] && ptr_w'(i) >= ptr_q && !found_hi) begin
                found_hi = 1'b1;
                sel_hi   = ptr_w'(i);
            end
        end
        sel   = found_hi ? sel_hi : sel_lo;
        grant = found_lo && ready;

        gnt_d = '0;
        for (int i = 0; i < num_ports; i++) begin
            gnt_d[i] = grant && (sel == ptr_w'(i));
        end
        sel_tail = |(gnt_d & tail);

        ptr_d     = ptr_q;
        lock_d    = lock_q;
        lock_ip_d = lock_ip_q;
        if (grant) begin
            // Only a packet-opening grant moves the pointer.
            if (!lock_q) begin
                ptr_d = rr_next(sel, num_ports);
            end
            if (lock_packets) begin
                lock_d    = !sel_tail;
                lock_ip_d = sel;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_ip_q <= '0;
            gnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_ip_q <= lock_ip_d;
            gnt_q     <= gnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = lock_q;

endmodule

// File: rtl/rtr_xbr_allocator.sv
// Crossbar switch allocator: transposes input-major requests into per-output
// columns, runs one arbiter per output and collects the crosspoint controls.
module rtr_xbr_allocator
    import rtr_xbr_allocator_pkg::*;
#(
    parameter int unsigned num_ports    = 5,
    parameter bit          lock_packets = lock_packets_on
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ports*num_ports-1:0] req_ip_op,
    input  logic [num_ports-1:0]           tail_ip,
    input  logic [num_ports-1:0]           ready_op,
    output logic [num_ports-1:0]           gnt_ip,
    output logic [num_ports*num_ports-1:0] ctrl_in_op_ip,
    output logic [num_ports-1:0]           busy_op
);

    if (num_ports < num_ports_min || num_ports > num_ports_max) begin : g_bad_param
        $error("rtr_xbr_allocator: num_ports outside supported range");
    end

    logic [num_ports*num_ports-1:0] req_op_ip;

    for (genvar op = 0; op < num_ports; op++) begin : g_out
        for (genvar ip = 0; ip < num_ports; ip++) begin : g_tr
            assign req_op_ip[op*num_ports+ip] = req_ip_op[ip*num_ports+op];
        end

        rtr_xbr_out_arbiter #(
            .num_ports    (num_ports),
            .lock_packets (lock_packets)
        ) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (req_op_ip[op*num_ports +: num_ports]),
            .tail  (tail_ip),
            .ready (ready_op[op]),
            .gnt   (ctrl_in_op_ip[op*num_ports +: num_ports]),
            .busy  (busy_op[op])
        );
    end

    // Each input is granted by at most one output, so OR-ing the blocks is exact.
    always_comb begin
        gnt_ip = '0;
        for (int op = 0; op < num_ports; op++) begin
            gnt_ip |= ctrl_in_op_ip[op*num_ports +: num_ports];
        end
    end

    for (genvar ip = 0; ip < num_ports; ip++) begin : g_chk
        a_single_output: assert property (@(posedge clk) disable iff (reset)
            $onehot0(req_ip_op[ip*num_ports +: num_ports]))
            else $error("rtr_xbr_allocator: input %0d requests several outputs", ip);
    end

endmodule

// File: tb/tb_rtr_xbr_allocator.sv
// Bench for rtr_xbr_allocator: directed vector table through a scoreboard,
// a mid-packet reset sequence, then random packet traffic with rule checks.
module tb_rtr_xbr_allocator;

    localparam int n  = 5;
    localparam int nn = n * n;
    localparam logic [n-1:0] all_rdy = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic [nn-1:0] req_ip_op;
    logic [n-1:0]  tail_ip;
    logic [n-1:0]  ready_op;
    logic [n-1:0]  gnt_ip;
    logic [nn-1:0] ctrl_in_op_ip;
    logic [n-1:0]  busy_op;

    always #5 clk = ~clk;

    rtr_xbr_allocator #(.num_ports(n), .lock_packets(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_ip_op     (req_ip_op),
        .tail_ip       (tail_ip),
        .ready_op      (ready_op),
        .gnt_ip        (gnt_ip),
        .ctrl_in_op_ip (ctrl_in_op_ip),
        .busy_op       (busy_op)
    );

    typedef struct {
        logic [nn-1:0] req;
        logic [n-1:0]  tail;
        logic [n-1:0]  ready;
        logic [n-1:0]  gnt;
        logic [nn-1:0] ctrl;
        logic [n-1:0]  busy;
    } vec_t;

    typedef struct {
        logic [n-1:0]  gnt;
        logic [nn-1:0] ctrl;
        logic [n-1:0]  busy;
        string         tag;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic logic [nn-1:0] rq(input int ip, input int op);
        logic [nn-1:0] v;
        v = '0;
        v[ip*n+op] = 1'b1;
        return v;
    endfunction

    function automatic logic [nn-1:0] cx(input int op, input int ip);
        logic [nn-1:0] v;
        v = '0;
        v[op*n+ip] = 1'b1;
        return v;
    endfunction

    function automatic logic [n-1:0] bt(input int i);
        logic [n-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        n_checks++;
        if (act <= lim) n_pass++;
        else $display("FAIL %s: got %0d, limit %0d", name, act, lim);
    endtask

    // Drive one vector, queue its expectation, compare after the next edge.
    task automatic apply(input vec_t v, input logic rst, input string tag);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        req_ip_op = v.req;
        tail_ip   = v.tail;
        ready_op  = v.ready;
        e.gnt  = v.gnt;
        e.ctrl = v.ctrl;
        e.busy = v.busy;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, " gnt"},  32'(gnt_ip),        32'(e.gnt));
        check({e.tag, " ctrl"}, 32'(ctrl_in_op_ip), 32'(e.ctrl));
        check({e.tag, " busy"}, 32'(busy_op),       32'(e.busy));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Random-traffic bookkeeping
    bit            act[n];
    bit            head[n];
    int            dst[n];
    int            rem[n];
    int            owner[n];
    int            wait_cnt[n];
    logic [nn-1:0] r, allowed;
    logic [n-1:0]  t, rd, or_g, col;
    int            bad_op, bad_ip;

    initial begin
        vec_t rv, perm;
        logic [nn-1:0] perm_req, perm_ctrl;

        reset = 1'b1; req_ip_op = '0; tail_ip = '0; ready_op = '0;

        // Requests during reset must not produce grants.
        rv = '{rq(0, 0) | rq(1, 1), bt(0) | bt(1), all_rdy, '0, '0, '0};
        apply(rv, 1'b1, "reset0");
        apply(rv, 1'b1, "reset1");

        perm_req  = rq(0, 1) | rq(1, 2) | rq(2, 3) | rq(3, 4) | rq(4, 0);
        perm_ctrl = cx(1, 0) | cx(2, 1) | cx(3, 2) | cx(4, 3) | cx(0, 4);

        // Round robin on output 2 from pointer 0, then pointer 4 and wrap.
        tbl.push_back('{rq(1, 2) | rq(3, 2), bt(1) | bt(3), all_rdy, bt(1), cx(2, 1), '0});
        tbl.push_back('{rq(3, 2), bt(3), all_rdy, bt(3), cx(2, 3), '0});
        tbl.push_back('{rq(0, 2) | rq(4, 2), bt(0) | bt(4), all_rdy, bt(4), cx(2, 4), '0});
        tbl.push_back('{rq(0, 2) | rq(4, 2), bt(0), all_rdy, bt(0), cx(2, 0), '0});
        tbl.push_back('{'0, '0, all_rdy, '0, '0, '0});
        // Four-flit packet ip0->op4 with ip2 contending.
        tbl.push_back('{rq(0, 4) | rq(2, 4), bt(2), all_rdy, bt(0), cx(4, 0), bt(4)});
        tbl.push_back('{rq(0, 4) | rq(2, 4), bt(2), all_rdy, bt(0), cx(4, 0), bt(4)});
        tbl.push_back('{rq(0, 4) | rq(2, 4), bt(2), all_rdy, bt(0), cx(4, 0), bt(4)});
        tbl.push_back('{rq(0, 4) | rq(2, 4), bt(0) | bt(2), all_rdy, bt(0), cx(4, 0), '0});
        tbl.push_back('{rq(2, 4), bt(2), all_rdy, bt(2), cx(4, 2), '0});
        // Bubble: locked input drops its request, other input must wait.
        tbl.push_back('{rq(1, 0), '0, all_rdy, bt(1), cx(0, 1), bt(0)});
        tbl.push_back('{rq(3, 0), bt(3), all_rdy, '0, '0, bt(0)});
        tbl.push_back('{rq(1, 0) | rq(3, 0), bt(1) | bt(3), all_rdy, bt(1), cx(0, 1), '0});
        tbl.push_back('{rq(3, 0), bt(3), all_rdy, bt(3), cx(0, 3), '0});
        // Output 1 not ready for three cycles.
        tbl.push_back('{rq(4, 1), bt(4), 5'b11101, '0, '0, '0});
        tbl.push_back('{rq(4, 1), bt(4), 5'b11101, '0, '0, '0});
        tbl.push_back('{rq(4, 1), bt(4), 5'b11101, '0, '0, '0});
        tbl.push_back('{rq(4, 1), bt(4), all_rdy, bt(4), cx(1, 4), '0});
        tbl.push_back('{rq(0, 1) | rq(2, 1), bt(0) | bt(2), all_rdy, bt(0), cx(1, 0), '0});
        // Permutation: all outputs granted in one cycle.
        tbl.push_back('{perm_req, '1, all_rdy, '1, perm_ctrl, '0});
        tbl.push_back('{perm_req, '0, all_rdy, '1, perm_ctrl, '1});
        tbl.push_back('{perm_req, '1, all_rdy, '1, perm_ctrl, '0});

        foreach (tbl[i]) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Reset in the middle of a packet on output 3.
        apply('{rq(1, 3), '0, all_rdy, bt(1), cx(3, 1), bt(3)}, 1'b0, "mid_head");
        apply('{rq(1, 3), '0, all_rdy, '0, '0, '0}, 1'b1, "mid_reset");
        apply('{rq(2, 3), bt(2), all_rdy, bt(2), cx(3, 2), '0}, 1'b0, "post_reset");
        apply('{'0, '0, all_rdy, '0, '0, '0}, 1'b0, "post_idle");

        // Random packet traffic.
        apply('{'0, '0, all_rdy, '0, '0, '0}, 1'b1, "rnd_reset");
        for (int i = 0; i < n; i++) begin
            act[i] = 1'b0; head[i] = 1'b0; dst[i] = 0; rem[i] = 0;
            owner[i] = -1; wait_cnt[i] = 0;
        end

        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            r = '0; t = '0; rd = '0;
            for (int ip = 0; ip < n; ip++) begin
                if (!act[ip] && $urandom_range(3) == 0) begin
                    act[ip]  = 1'b1;
                    head[ip] = 1'b1;
                    dst[ip]  = int'($urandom_range(n - 1));
                    rem[ip]  = 1 + int'($urandom_range(3));
                end
                if (act[ip] && (head[ip] || $urandom_range(7) != 0)) begin
                    r[ip*n+dst[ip]] = 1'b1;
                    t[ip] = (rem[ip] == 1);
                end
            end
            for (int op = 0; op < n; op++) rd[op] = ($urandom_range(9) < 8);
            reset = 1'b0; req_ip_op = r; tail_ip = t; ready_op = rd;
            @(posedge clk);
            #1;

            allowed = '0;
            for (int ip = 0; ip < n; ip++)
                for (int op = 0; op < n; op++)
                    allowed[op*n+ip] = r[ip*n+op] & rd[op];
            check("rnd spurious", 32'(ctrl_in_op_ip & ~allowed), 32'd0);

            bad_op = 0; bad_ip = 0; or_g = '0;
            for (int op = 0; op < n; op++) begin
                if (!$onehot0(ctrl_in_op_ip[op*n +: n])) bad_op++;
                or_g |= ctrl_in_op_ip[op*n +: n];
            end
            for (int ip = 0; ip < n; ip++) begin
                col = '0;
                for (int op = 0; op < n; op++) col[op] = ctrl_in_op_ip[op*n+ip];
                if (!$onehot0(col)) bad_ip++;
            end
            check("rnd onehot_out", 32'(bad_op), 32'd0);
            check("rnd onehot_in",  32'(bad_ip), 32'd0);
            check("rnd gnt_ip",     32'(gnt_ip), 32'(or_g));

            for (int op = 0; op < n; op++) begin
                for (int ip = 0; ip < n; ip++) begin
                    if (ctrl_in_op_ip[op*n+ip]) begin
                        if (owner[op] == -1) check("rnd head_expected", 32'(head[ip]), 32'd1);
                        else                 check("rnd interleave", 32'(ip), 32'(owner[op]));
                        if (head[ip]) begin
                            for (int w = 0; w < n; w++)
                                if (w != ip && act[w] && head[w] && dst[w] == op) wait_cnt[w]++;
                            check_le("rnd starvation", wait_cnt[ip], n);
                            wait_cnt[ip] = 0;
                        end
                        owner[op] = (rem[ip] == 1) ? -1 : ip;
                        head[ip]  = 1'b0;
                        rem[ip]--;
                        if (rem[ip] == 0) act[ip] = 1'b0;
                    end
                end
                check("rnd busy", 32'(busy_op[op]), 32'(owner[op] != -1));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rtr_xbr_allocator.md
RTR_XBR_ALLOCATOR -- requirements
Module: rtr_xbr_allocator

Interface
REQ-001 Parameter: num_ports, 5, number of crossbar input and output ports (2..16).
REQ-002 Parameter: lock_packets, 1, when 1 an output stays held by one input from head to tail; when 0 every flit arbitrates.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_ip_op  input  num_ports*num_ports  request from input ip to output op at bit ip*num_ports+op; at most one bit set per input.
REQ-006 Port: tail_ip  input  num_ports  the requesting flit at input ip is a packet tail; valid only with a request.
REQ-007 Port: ready_op  input  num_ports  output op can accept a flit this cycle (credit available).
REQ-008 Port: gnt_ip  output  num_ports  registered; input ip's request was granted, flit traverses next cycle.
REQ-009 Port: ctrl_in_op_ip  output  num_ports*num_ports  registered crosspoint controls, output-major, bit op*num_ports+ip; drives the crossbar directly.
REQ-010 Port: busy_op  output  num_ports  output op is currently locked to a packet.

Function
REQ-011 Each output op shall select at most one input per cycle among inputs ip whose req bit for op is set, using a round-robin priority.
REQ-012 No grant shall be issued on output op while ready_op[op] is 0; the pointer and lock shall then remain unchanged.
REQ-013 Latency: a grant decided in cycle t shall appear on gnt_ip and ctrl_in_op_ip in cycle t+1; the outputs are all-zero in cycles with no grant.
REQ-014 ctrl_in_op_ip shall be one-hot or zero per output block and one-hot or zero per input column.
REQ-015 Round-robin: after a grant to input g on output op, the priority pointer for op shall move to (g+1) mod num_ports; wrap-around from num_ports-1 to 0.
REQ-016 Pointer initial value after reset shall be 0 for every output.
REQ-017 With lock_packets=1, a grant of a non-tail flit shall lock op to that input; while locked, only that input is eligible on op.
REQ-018 A grant with tail_ip set shall clear the lock in the same update; a single-flit packet (head=tail) shall never lock.
REQ-019 A locked input dropping its request shall produce no grant on op; the lock and pointer shall be held (bubble).
REQ-020 Pointer shall not advance on locked-continuation grants; it advances only on the grant that opens a packet.
REQ-021 Simultaneous release and new request: an output freed by a tail grant in cycle t shall be arbitrable in cycle t+1.
REQ-022 busy_op[op] shall equal the registered lock-valid bit of op.
REQ-023 A request with more than one output bit set shall be treated as illegal; a simulation assertion shall fire; the RTL behaviour is undefined.

Reset
REQ-024 Reset asserted in any cycle shall, at the next edge, clear gnt_ip, ctrl_in_op_ip, busy_op, all locks, and all pointers to 0.
REQ-025 Reset mid-packet shall abandon the lock; no grant shall be issued in the cycle following reset deassertion unless requested in the first cycle after it.

Structure
REQ-026 A per-output sub-module rtr_xbr_out_arbiter shall hold one pointer, one lock register and the round-robin selection; it is instantiated num_ports times.
REQ-027 The ip/op bit-index conversion (input-major to output-major) shall be a pure wire transpose in the top level.
REQ-028 The lock_packets enable values and the port-count limits shall live as constants in the shared router constants package.

Verification
REQ-029 Reset, then req_ip_op requests from inputs 1 and 3 both to output 2, all ready, tails set -> cycle+1: gnt_ip=00010b (ip1 bit); next cycle: ip3 granted; pointer then = 4.
REQ-030 Input 0 sends a 4-flit packet to output 4 while input 2 also requests output 4 -> ip0 gets four consecutive grants, busy_op[4]=1 for three cycles, ip2 granted in the cycle after the tail.
REQ-031 ready_op[1]=0 for 3 cycles with input 4 requesting output 1 -> no gnt for 3 cycles; grant one cycle after ready rises; pointer unchanged until then.
REQ-032 All 5 inputs request distinct outputs (permutation ip->(ip+1) mod 5) -> all five grants in one cycle; ctrl_in_op_ip is a permutation matrix.
REQ-033 Reset asserted mid-packet on output 3 -> busy_op=0 next cycle; a different input's head is granted on output 3 right after reset.
REQ-034 Random traffic for 10k cycles -> scoreboard checks one-hot rules (REQ-014), no packet interleaving per output, and no starvation beyond num_ports packets.
